// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, opcode map,
// opcode classes and the encodings of the ALU/immediate/result selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StBranch,
        StJump,
        StMem,
        StHalt
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [2:0] {
        ClsR,
        ClsIAlu,
        ClsLui,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal,
        ClsBad
    } opclass_e;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } aluctrl_e;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmU = 3'b011,
        ImmJ = 3'b100
    } immsrc_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10,
        ResImm = 2'b11
    } resultsrc_e;

    function automatic opclass_e classify(input logic [6:0] opcode);
        opclass_e cls;
        case (opcode)
            OpR:      cls = ClsR;
            OpIAlu:   cls = ClsIAlu;
            OpLui:    cls = ClsLui;
            OpLoad:   cls = ClsLoad;
            OpStore:  cls = ClsStore;
            OpBranch: cls = ClsBranch;
            OpJal:    cls = ClsJal;
            default:  cls = ClsBad;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control decode; also flags any funct3/funct7 combination
// that has no legal meaning for the instruction's opcode class.
module alu_decoder
    import ctrl_pkg::*;
(
    input  opclass_e   cls_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output aluctrl_e   aluctrl_o,
    output logic       illegal_o
);

    always_comb begin
        aluctrl_o = AluAdd;
        illegal_o = 1'b0;
        case (cls_i)
            ClsR: begin
                case (funct3_i)
                    3'b000: begin
                        if (funct7_i == 7'b0100000) begin
                            aluctrl_o = AluSub;
                        end else if (funct7_i != 7'b0000000) begin
                            illegal_o = 1'b1;
                        end
                    end
                    3'b111: begin
                        aluctrl_o = AluAnd;
                        illegal_o = (funct7_i != 7'b0000000);
                    end
                    3'b110: begin
                        aluctrl_o = AluOr;
                        illegal_o = (funct7_i != 7'b0000000);
                    end
                    3'b010: begin
                        aluctrl_o = AluSlt;
                        illegal_o = (funct7_i != 7'b0000000);
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            ClsIAlu: begin
                case (funct3_i)
                    3'b000:  aluctrl_o = AluAdd;
                    3'b111:  aluctrl_o = AluAnd;
                    3'b110:  aluctrl_o = AluOr;
                    3'b010:  aluctrl_o = AluSlt;
                    default: illegal_o = 1'b1;
                endcase
            end
            // Only word-sized accesses are supported.
            ClsLoad, ClsStore: illegal_o = (funct3_i != 3'b010);
            ClsBranch: begin
                aluctrl_o = AluSub;
                illegal_o = (funct3_i[2:1] != 2'b00);
            end
            ClsLui, ClsJal: illegal_o = 1'b0;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory sequencing with
// req/ready memory handshakes and a sticky illegal-instruction halt.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned I_WIDTH   = 32,
    parameter int unsigned ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [I_WIDTH-1:0]   instr,
    input  logic                 eq,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pcsrc,
    output logic                 alusrc,
    output logic [ALUCTRL_W-1:0] aluctrl,
    output logic [2:0]           immsrc,
    output logic                 regwrite,
    output logic [1:0]           resultsrc,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 illegal
);

    state_e   state_q, state_d;
    logic     illegal_q, illegal_d;
    opclass_e cls;
    aluctrl_e dec_aluctrl;
    logic     dec_illegal;
    logic     unused_instr;

    assign cls          = classify(instr[6:0]);
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .cls_i     (cls),
        .funct3_i  (instr[14:12]),
        .funct7_i  (instr[31:25]),
        .aluctrl_o (dec_aluctrl),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch: if (imem_ready) state_d = StDecode;
            StDecode: begin
                if (dec_illegal) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else begin
                    case (cls)
                        ClsR, ClsIAlu, ClsLui: state_d = StExec;
                        ClsLoad, ClsStore:     state_d = StMem;
                        ClsBranch:             state_d = StBranch;
                        ClsJal:                state_d = StJump;
                        default: begin
                            state_d   = StHalt;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            StExec, StBranch, StJump: state_d = StFetch;
            StMem: if (dmem_ready) state_d = StFetch;
            StHalt: illegal_d = 1'b1;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs are gated by rst_n so a reset mid-handshake drops requests at once.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pcsrc     = 1'b0;
        alusrc    = 1'b0;
        aluctrl   = '0;
        immsrc    = ImmI;
        regwrite  = 1'b0;
        resultsrc = ResAlu;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        illegal   = illegal_q;
        if (rst_n) begin
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                StExec: begin
                    regwrite = 1'b1;
                    pc_we    = 1'b1;
                    if (cls == ClsLui) begin
                        immsrc    = ImmU;
                        resultsrc = ResImm;
                    end else begin
                        aluctrl = ALUCTRL_W'(dec_aluctrl);
                        alusrc  = (cls == ClsIAlu);
                    end
                end
                StMem: begin
                    aluctrl  = ALUCTRL_W'(dec_aluctrl);
                    alusrc   = 1'b1;
                    immsrc   = (cls == ClsStore) ? ImmS : ImmI;
                    dmem_req = 1'b1;
                    dmem_we  = (cls == ClsStore);
                    if (dmem_ready) begin
                        pc_we = 1'b1;
                        if (cls == ClsLoad) begin
                            regwrite  = 1'b1;
                            resultsrc = ResMem;
                        end
                    end
                end
                StBranch: begin
                    aluctrl = ALUCTRL_W'(dec_aluctrl);
                    immsrc  = ImmB;
                    pc_we   = 1'b1;
                    pcsrc   = instr[12] ? ~eq : eq;
                end
                StJump: begin
                    immsrc    = ImmJ;
                    regwrite  = 1'b1;
                    resultsrc = ResPc4;
                    pc_we     = 1'b1;
                    pcsrc     = 1'b1;
                end
                StDecode, StHalt: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a behavioural memory drives the
// handshakes and a scoreboard checks the commit (pc_we) cycle of each instruction.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] aluctrl;
        logic       alusrc;
        logic [2:0] immsrc;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       pcsrc;
        logic       dmem_req;
        logic       dmem_we;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        eq;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic        pcsrc;
    logic        alusrc;
    logic [2:0]  aluctrl;
    logic [2:0]  immsrc;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        dmem_req;
    logic        dmem_we;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_obs;
    exp_t mon_exp;

    multicycle_ctrl #(
        .I_WIDTH   (32),
        .ALUCTRL_W (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .eq         (eq),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pcsrc      (pcsrc),
        .alusrc     (alusrc),
        .aluctrl    (aluctrl),
        .immsrc     (immsrc),
        .regwrite   (regwrite),
        .resultsrc  (resultsrc),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .illegal    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(input logic [2:0] a, input logic s, input logic [2:0] i,
                                input logic rw, input logic [1:0] r, input logic p,
                                input logic dq, input logic dw);
        return {a, s, i, rw, r, p, dq, dw};
    endfunction

    // Scoreboard: every commit cycle pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && pc_we) begin
            mon_obs = {aluctrl, alusrc, immsrc, regwrite, resultsrc, pcsrc, dmem_req, dmem_we};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got pc_we with outputs %h, required no commit",
                         mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    errors++;
                    $display("FAIL commit instr=%h: got %h, required %h", instr, mon_obs,
                             mon_exp);
                end
            end
        end
    end

    task automatic run_instr(input string nm, input logic [31:0] ins, input logic e,
                             input int dwait, input exp_t ex, input int exp_cyc);
        int cyc = 0, dcnt = 0, nreq = 0, nwe = 0, nrw = 0, nir = 0;
        int exp_req, exp_we, exp_rw;
        bit done = 0;
        exp_q.push_back(ex);
        instr      = ins;
        eq         = e;
        imem_ready = 1'b1;
        while (!done && cyc < 32) begin
            if (dmem_req) begin
                dmem_ready = (dcnt >= dwait);
                dcnt++;
            end else begin
                dmem_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (dmem_req) nreq++;
            if (dmem_req && dmem_we) nwe++;
            if (regwrite) nrw++;
            if (ir_we) nir++;
            if (pc_we) done = 1;
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        exp_req = ex.dmem_req ? dwait + 1 : 0;
        exp_we  = ex.dmem_we ? dwait + 1 : 0;
        exp_rw  = ex.regwrite ? 1 : 0;
        checks += 5;
        if (cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s cycles: got %0d, required %0d", nm, cyc, exp_cyc);
        end
        if (nreq !== exp_req) begin
            errors++;
            $display("FAIL %s dmem_req_cycles: got %0d, required %0d", nm, nreq, exp_req);
        end
        if (nwe !== exp_we) begin
            errors++;
            $display("FAIL %s dmem_we_cycles: got %0d, required %0d", nm, nwe, exp_we);
        end
        if (nrw !== exp_rw) begin
            errors++;
            $display("FAIL %s regwrite_cycles: got %0d, required %0d", nm, nrw, exp_rw);
        end
        if (nir !== 1) begin
            errors++;
            $display("FAIL %s ir_we_cycles: got %0d, required 1", nm, nir);
        end
    endtask

    task automatic test_reset();
        logic [18:0] outs;
        rst_n = 1'b0;
        instr = 32'h0;
        eq = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            outs = {imem_req, ir_we, pc_we, pcsrc, alusrc, aluctrl, immsrc, regwrite,
                    resultsrc, dmem_req, dmem_we, illegal};
            checks++;
            if (outs !== 19'h0) begin
                errors++;
                $display("FAIL reset_outputs: got %h, required 0", outs);
            end
            repeat (2) @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_fetch: got imem_req=%b, required 1", imem_req);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        run_instr("add",  32'h002081B3, 1'b0, 0, mk(3'b000, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("sub",  32'h402081B3, 1'b0, 0, mk(3'b001, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("slti", 32'h0050A193, 1'b0, 0, mk(3'b101, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("and",  32'h0020F1B3, 1'b0, 0, mk(3'b010, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("or",   32'h0020E1B3, 1'b0, 0, mk(3'b011, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("slt",  32'h0020A1B3, 1'b0, 0, mk(3'b101, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("addi", 32'h00508193, 1'b0, 0, mk(3'b000, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("andi", 32'h0050F193, 1'b0, 0, mk(3'b010, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("ori",  32'h0050E193, 1'b0, 0, mk(3'b011, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("lui",  32'h000011B7, 1'b0, 0, mk(3'b000, 1'b0, 3'b011, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0), 3);
    endtask

    task automatic test_branch();
        run_instr("beq_eq1", 32'h00208063, 1'b1, 0, mk(3'b001, 1'b0, 3'b010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), 3);
        run_instr("beq_eq0", 32'h00208063, 1'b0, 0, mk(3'b001, 1'b0, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("bne_eq1", 32'h00209063, 1'b1, 0, mk(3'b001, 1'b0, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        run_instr("bne_eq0", 32'h00209063, 1'b0, 0, mk(3'b001, 1'b0, 3'b010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), 3);
    endtask

    task automatic test_jump();
        run_instr("jal", 32'h000000EF, 1'b0, 0, mk(3'b000, 1'b0, 3'b100, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0), 3);
    endtask

    task automatic test_mem();
        run_instr("lw_wait3", 32'h0000A183, 1'b0, 3, mk(3'b000, 1'b1, 3'b000, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0), 6);
        run_instr("sw_wait3", 32'h0020A023, 1'b0, 3, mk(3'b000, 1'b1, 3'b001, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1), 6);
        run_instr("lw_wait0", 32'h0000A183, 1'b0, 0, mk(3'b000, 1'b1, 3'b000, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0), 3);
        run_instr("sw_wait1", 32'h0020A023, 1'b0, 1, mk(3'b000, 1'b1, 3'b001, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1), 4);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({illegal, imem_req} !== 2'b01) begin
            errors++;
            $display("FAIL %s post_reset: got illegal,imem_req=%b%b, required 01", nm, illegal,
                     imem_req);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3] = '{32'h0000007F, 32'h002091B3, 32'h00008183};
        logic [5:0]  obs;
        for (int n = 0; n < 3; n++) begin
            instr      = bad[n];
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                obs = {illegal, imem_req, ir_we, pc_we, regwrite, dmem_req};
                checks++;
                if (obs !== 6'b100000) begin
                    errors++;
                    $display("FAIL halt instr=%h cycle %0d: got %b, required 100000", bad[n], k,
                             obs);
                end
                @(posedge clk);
                #1;
            end
            do_reset("halt_recover");
        end
    endtask

    task automatic test_async_reset();
        imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait_req: got %b, required 1", imem_req);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_drop_imem_req: got %b, required 0", imem_req);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        instr      = 32'h0000A183;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL mem_wait_req: got %b, required 1", dmem_req);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_we, pc_we} !== 3'b000) begin
            errors++;
            $display("FAIL async_drop_dmem_req: got %b, required 000", {dmem_req, dmem_we, pc_we});
        end
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({imem_req, illegal, dmem_req} !== 3'b100) begin
            errors++;
            $display("FAIL async_restart_fetch: got %b, required 100",
                     {imem_req, illegal, dmem_req});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_mem();
        test_illegal();
        test_async_reset();
        run_instr("add_after_reset", 32'h002081B3, 1'b0, 0,
                  mk(3'b000, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 3);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit that issues the ALU control interface (alusrc, aluctrl) and consumes the ALU's eq flag.
- Sequences fetch/decode/execute/memory through an FSM and drives PC, IR, register-file and data-memory strobes.
- Instruction and data memories use a req/ready handshake, so any wait-state count is tolerated.
- Sits between IR/PC/regfile/ALU datapath and memory.

Parameters:
- I_WIDTH, 32, instruction width
- ALUCTRL_W, 3, width of aluctrl

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  current IR contents; stable from the cycle after ir_we
- eq  in  1  ALU equality flag (aluop1 == selected op2)
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load IR from instruction memory
- pc_we  out  1  update PC at end of cycle
- pcsrc  out  1  0 = PC+4, 1 = PC+imm
- alusrc  out  1  0 = register op2, 1 = immediate
- aluctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- immsrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- regwrite  out  1  register-file write strobe
- resultsrc  out  2  00 aluout, 01 mem data, 10 PC+4, 11 imm
- dmem_req  out  1  data access request
- dmem_we  out  1  store qualifier; valid only with dmem_req
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, illegal=0.
  - All strobes 0; aluctrl=000, alusrc=0, immsrc=000, resultsrc=00, pcsrc=0.
  - Reset asserted mid-handshake drops imem_req/dmem_req immediately, not at the next edge.
- Output timing:
  - Outputs are combinational from state, instr and the ready inputs.
  - Only state and illegal are registered.
  - Every output not listed for a state is 0.
- States: FETCH, DECODE, EXEC, BRANCH, JUMP, MEM, HALT.
- FETCH:
  - imem_req=1, held until imem_ready.
  - In the imem_ready cycle: ir_we=1, next state DECODE.
  - Otherwise remain in FETCH.
- DECODE (always 1 cycle), dispatch on instr[6:0]:
  - 0110011 (R), 0010011 (I-ALU), 0110111 (lui) -> EXEC
  - 0000011 (lw), 0100011 (sw) -> MEM
  - 1100011 -> BRANCH
  - 1101111 -> JUMP
  - Anything else, or any illegal funct combination -> HALT with illegal set.
- EXEC (1 cycle), then FETCH:
  - R: alusrc=0, regwrite=1, resultsrc=00, pc_we=1, pcsrc=0.
  - I-ALU: same as R except alusrc=1, immsrc=000.
  - lui: immsrc=011, resultsrc=11, regwrite=1, pc_we=1.
- ALU decode table:
  - R, funct3 000: add if funct7=0000000; sub if funct7=0100000.
  - R, funct3 111/110/010 -> 010/011/101 with funct7=0000000.
  - R, any other funct7/funct3 combination -> illegal.
  - I-ALU, funct3 000/111/110/010 -> 000/010/011/101; other funct3 -> illegal.
- MEM:
  - aluctrl=000, alusrc=1; immsrc=000 for lw, 001 for sw.
  - dmem_req=1; dmem_we=1 for sw.
  - funct3 != 010 is illegal; detected in DECODE.
  - Hold until dmem_ready. In the dmem_ready cycle: pc_we=1, pcsrc=0; lw also asserts regwrite=1, resultsrc=01. Next state FETCH.
- BRANCH (1 cycle), then FETCH:
  - aluctrl=001, alusrc=0, immsrc=010, pc_we=1.
  - pcsrc = eq for beq (funct3 000), !eq for bne (funct3 001); other funct3 illegal.
- JUMP (1 cycle), then FETCH:
  - immsrc=100, regwrite=1, resultsrc=10, pc_we=1, pcsrc=1.
- HALT: absorbing until reset; illegal=1; no requests or strobes issued.
- Latency with zero-wait memory:
  - ALU/branch/jump/lui: 3 cycles.
  - lw/sw: 3 cycles plus data wait states.
- Simultaneous events: a ready input asserted while its req is 0 is ignored.
- rd=x0 writes are suppressed by the regfile, not here.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - opcode localparams
  - aluctrl enum (ADD/SUB/AND/OR/SLT)
  - immsrc enum
  - resultsrc enum
- Sub-module alu_decoder (combinational): opcode class, funct3, funct7 -> aluctrl, illegal.

Test Plan:
- add x3,x1,x2 (0x002081B3), zero-wait -> 3 cycles; EXEC cycle shows aluctrl=000, alusrc=0, regwrite=1, pc_we=1, pcsrc=0.
- sub (funct7=0100000) and slti (funct3 010) -> aluctrl=001 and aluctrl=101 with alusrc=1, immsrc=000.
- beq with eq=1, then eq=0; bne with eq=1 -> pcsrc=1, 0, 0 respectively; pc_we=1 and aluctrl=001 in all three.
- lw with dmem_ready low 3 cycles -> dmem_req held 4 cycles, dmem_we=0; regwrite=1, resultsrc=01, pc_we=1 only in the ready cycle. sw: same hold pattern, dmem_we=1, regwrite never asserted.
- Opcode 0x7F, then R funct3=001 -> HALT, illegal=1 sticky, imem_req=0 thereafter.
- rst_n low during FETCH wait and during MEM wait -> imem_req/dmem_req drop without a clock edge; after release FETCH restarts and illegal=0.
